// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit multiplexer with an optional select register (load or scan)
// and an optional output/valid register stage.
module mux_n_pipe #(
    parameter int WIDTH = 18,
    parameter int N     = 8,
    parameter int SREG  = 1,
    parameter int OREG  = 1,
    localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [N*WIDTH-1:0]   IN,
    input  logic [SELW-1:0]      SEL,
    input  logic                 CESEL,
    input  logic                 MODE,
    input  logic                 CEOUT,
    input  logic                 VALID_IN,
    output logic [WIDTH-1:0]     OUT,
    output logic [SELW-1:0]      SEL_Q,
    output logic                 VALID_OUT
);

    localparam int              NPAD     = 1 << SELW;
    localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);

    logic [SELW-1:0]  sel_eff_s;
    logic [WIDTH-1:0] ch_s [NPAD];
    logic [WIDTH-1:0] mux_d;

    // Select codes past N-1 land on zero-padded slots, so out-of-range reads give 0.
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_ch
        if (gi < N) begin : g_in
            assign ch_s[gi] = IN[gi*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_s[gi] = '0;
        end
    end

    assign mux_d = ch_s[sel_eff_s];
    assign SEL_Q = sel_eff_s;

    if (SREG != 0) begin : g_sreg
        logic [SELW-1:0] sel_q;
        logic [SELW-1:0] sel_d;

        // Next select: hold, load SEL, or scan step that also recovers from out-of-range
        always_comb begin
            sel_d = sel_q;
            if (CESEL) begin
                if (MODE) begin
                    if (sel_q >= LAST_SEL) begin
                        sel_d = '0;
                    end else begin
                        sel_d = sel_q + SELW'(1);
                    end
                end else begin
                    sel_d = SEL;
                end
            end else begin
                sel_d = sel_q;
            end
        end

        // Select register
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
                sel_q <= '0;
            end else begin
                sel_q <= sel_d;
            end
        end

        assign sel_eff_s = sel_q;
    end else begin : g_scomb
        logic unused_sel_s;
        assign unused_sel_s = ^{CESEL, MODE};
        assign sel_eff_s    = SEL;
    end

    if (OREG != 0) begin : g_oreg
        logic [WIDTH-1:0] out_q;
        logic [WIDTH-1:0] out_d;
        logic             valid_q;
        logic             valid_d;

        // Output stage next state: capture on CEOUT, otherwise hold
        always_comb begin
            out_d   = out_q;
            valid_d = valid_q;
            if (CEOUT) begin
                out_d   = mux_d;
                valid_d = VALID_IN;
            end else begin
                out_d   = out_q;
                valid_d = valid_q;
            end
        end

        // Output and valid registers
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                out_q   <= out_d;
                valid_q <= valid_d;
            end
        end

        assign OUT       = out_q;
        assign VALID_OUT = valid_q;
    end else begin : g_ocomb
        logic unused_out_s;
        assign unused_out_s = ^{CEOUT, CLK, RST_n};
        assign OUT          = mux_d;
        assign VALID_OUT    = VALID_IN;
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: registered N=8 and N=5 builds plus a fully
// combinational N=8 build, all driven from one shared stimulus.
module tb_mux_n_pipe;

    typedef struct packed {
        int sel0;
        int sel1;
        int out0;
        int out1;
        int vld0;
        int vld1;
    } exp_t;

    logic        CLK;
    logic        RST_n;
    logic [2:0]  SEL;
    logic        MODE;
    logic        CESEL;
    logic        CEOUT;
    logic        VALID_IN;
    logic [63:0] in8;
    logic [39:0] in5;
    logic [7:0]  out_a, out_b, out_c;
    logic [2:0]  selq_a, selq_b, selq_c;
    logic        vld_a, vld_b, vld_c;

    int   n_vec;
    int   n_err;
    int   m_sel [2];
    int   m_out [2];
    int   m_vld [2];
    int   nch   [2];
    exp_t sb [$];

    mux_n_pipe #(.WIDTH(8), .N(8), .SREG(1), .OREG(1)) u_dut_a (
        .CLK(CLK), .RST_n(RST_n), .IN(in8), .SEL(SEL), .CESEL(CESEL), .MODE(MODE),
        .CEOUT(CEOUT), .VALID_IN(VALID_IN), .OUT(out_a), .SEL_Q(selq_a), .VALID_OUT(vld_a));

    mux_n_pipe #(.WIDTH(8), .N(5), .SREG(1), .OREG(1)) u_dut_b (
        .CLK(CLK), .RST_n(RST_n), .IN(in5), .SEL(SEL), .CESEL(CESEL), .MODE(MODE),
        .CEOUT(CEOUT), .VALID_IN(VALID_IN), .OUT(out_b), .SEL_Q(selq_b), .VALID_OUT(vld_b));

    mux_n_pipe #(.WIDTH(8), .N(8), .SREG(0), .OREG(0)) u_dut_c (
        .CLK(CLK), .RST_n(RST_n), .IN(in8), .SEL(SEL), .CESEL(CESEL), .MODE(MODE),
        .CEOUT(CEOUT), .VALID_IN(VALID_IN), .OUT(out_c), .SEL_Q(selq_c), .VALID_OUT(vld_c));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int ch_val(input int k, input int s);
        return (s < nch[k]) ? (16 + s) : 0;
    endfunction

    // Drive one vector, check the combinational build, predict, clock, compare
    task automatic step(input int s, input logic md, input logic ce, input logic ceo, input logic vi);
        exp_t e;
        int   mux;
        SEL = 3'(s); MODE = md; CESEL = ce; CEOUT = ceo; VALID_IN = vi;
        #1;
        chk("comb_out", 32'(out_c), 32'(16 + s));
        chk("comb_sel", 32'(selq_c), 32'(s));
        chk("comb_vld", 32'(vld_c), 32'(vi));
        for (int k = 0; k < 2; k++) begin
            mux = ch_val(k, m_sel[k]);
            if (ceo) begin
                m_out[k] = mux;
                m_vld[k] = int'(vi);
            end
            if (ce) begin
                if (md) m_sel[k] = (m_sel[k] >= nch[k] - 1) ? 0 : m_sel[k] + 1;
                else    m_sel[k] = s;
            end
        end
        e = '{sel0: m_sel[0], sel1: m_sel[1], out0: m_out[0], out1: m_out[1],
              vld0: m_vld[0], vld1: m_vld[1]};
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("a_sel", 32'(selq_a), 32'(e.sel0));
            chk("a_out", 32'(out_a),  32'(e.out0));
            chk("a_vld", 32'(vld_a),  32'(e.vld0));
            chk("b_sel", 32'(selq_b), 32'(e.sel1));
            chk("b_out", 32'(out_b),  32'(e.out1));
            chk("b_vld", 32'(vld_b),  32'(e.vld1));
        end
    endtask

    // Assert reset between edges, check it bites without a clock, release before next edge
    task automatic do_reset();
        #2 RST_n = 1'b0;
        #1;
        chk("rst_a_sel", 32'(selq_a), 32'd0);
        chk("rst_a_out", 32'(out_a),  32'd0);
        chk("rst_a_vld", 32'(vld_a),  32'd0);
        chk("rst_b_sel", 32'(selq_b), 32'd0);
        chk("rst_b_out", 32'(out_b),  32'd0);
        chk("rst_b_vld", 32'(vld_b),  32'd0);
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_out[k] = 0; m_vld[k] = 0;
        end
        #2 RST_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        nch[0] = 8; nch[1] = 5;
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_out[k] = 0; m_vld[k] = 0;
        end
        for (int i = 0; i < 8; i++) in8[i*8 +: 8] = 8'(16 + i);
        for (int i = 0; i < 5; i++) in5[i*8 +: 8] = 8'(16 + i);
        RST_n = 1'b0; SEL = 3'd0; MODE = 1'b0; CESEL = 1'b0; CEOUT = 1'b0; VALID_IN = 1'b0;

        @(posedge CLK);
        #1;
        chk("init_sel", 32'(selq_a), 32'd0);
        chk("init_out", 32'(out_a),  32'd0);
        chk("init_vld", 32'(vld_a),  32'd0);
        @(negedge CLK);
        RST_n = 1'b1;

        // Static select, first edge after release is live
        step(5, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("static_selq", 32'(selq_a), 32'd5);
        step(5, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("static_out", 32'(out_a), 32'h15);

        // Scan from reset for 10 edges
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b1, 1'b1, 1'b1, 1'b1);
            chk("scan_seq", 32'(selq_a), 32'((i + 1) % 8));
        end

        // Mode 1->0 with CESEL loads SEL on the same edge
        step(4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mode_exit", 32'(selq_a), 32'd4);

        // Output enable frozen for 3 cycles while SEL and VALID_IN move
        step(1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(6, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b1, 1'b0, 1'b1);
        step(2, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ce_vld", 32'(vld_a), 32'd1);

        // Out-of-range select on the N=5 build, then scan recovers to 0
        step(6, 1'b0, 1'b1, 1'b1, 1'b1);
        step(6, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("oor_out", 32'(out_b), 32'd0);
        step(6, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("oor_wrap", 32'(selq_b), 32'd0);

        // Asynchronous reset from SEL_Q=3, OUT=8'h13
        step(3, 1'b0, 1'b1, 1'b1, 1'b1);
        step(3, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_out", 32'(out_a), 32'h13);
        do_reset();

        // Combinational build follows SEL inside one cycle
        SEL = 3'd2;
        #1 chk("comb_2", 32'(out_c), 32'h12);
        SEL = 3'd6;
        #1 chk("comb_6", 32'(out_c), 32'h16);

        // Reset mid-scan: scanning restarts from 0
        step(0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1);
        do_reset();
        step(0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("scan_restart", 32'(selq_a), 32'd1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
